phy_tx_multilane: RTL

PHY_TX_MULTILANE -- requirements
Module: phy_tx_multilane

---
 rtl/phy_tx_pkg.sv | 41 ++++
 rtl/phy_tx_lane.sv | 83 ++++++++
 rtl/phy_tx_multilane.sv | 89 ++++++++
 3 files changed

// File: rtl/phy_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phy_tx_pkg
// Description : Shared constants and helper functions for the multi-lane
//               serial transmitter (idle symbol, counter width, idle frame).
// Revision    : 1.0 - initial release
// ============================================================================
package phy_tx_pkg;

  // COM / idle symbol sent on a lane that has nothing to transmit
  localparam logic [7:0] IDLE_SYM_DEFAULT = 8'hBC;

  // Widest parallel word supported by the transmitter
  localparam int c_max_data_w = 64;

  // Width of the shared frame counter that runs 0..data_w-1
  function automatic int cnt_width(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

  // Width of the round-robin lane pointer that runs 0..lanes-1
  function automatic int rr_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // Idle frame: the idle symbol replicated once per byte of the data word.
  // Returned at full width; callers keep the low data_w bits.
  function automatic logic [c_max_data_w-1:0] idle_frame(input logic [7:0] sym,
                                                         input int data_w);
    logic [c_max_data_w-1:0] frame;
    frame = '0;
    for (int i = 0; i < c_max_data_w / 8; i++) begin
      if (i < data_w / 8) begin
        frame[i*8 +: 8] = sym;
      end
    end
    return frame;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phy_tx_lane.sv
`default_nettype none
// ============================================================================
// Module      : phy_tx_lane
// Description : One serial lane: a single-word holding buffer, a frame-wide
//               shift register, the data/idle frame flag and the registered
//               serial and valid outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module phy_tx_lane
  import phy_tx_pkg::*;
#(
  parameter int         DATA_W   = 32,
  parameter logic [7:0] IDLE_SYM = IDLE_SYM_DEFAULT
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_frame_end,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_buf_full,
  output logic              o_serial,
  output logic              o_valid
);

  localparam logic [c_max_data_w-1:0] c_idle_wide  = idle_frame(IDLE_SYM, DATA_W);
  localparam logic [DATA_W-1:0]       c_idle_frame = c_idle_wide[DATA_W-1:0];

  logic [DATA_W-1:0] r_buf;
  logic              r_buf_full;
  logic [DATA_W-1:0] r_shift;
  logic              r_data_flag;
  logic              r_serial;
  logic              r_valid;

  // Output stage: the MSB of the shift register together with its frame flag
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_serial <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_serial <= r_shift[DATA_W-1];
      r_valid  <= r_data_flag;
    end
  end

  // Shift register: shift left each clock, reload with buffer or idle at frame end
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift     <= c_idle_frame;
      r_data_flag <= 1'b0;
    end else if (i_frame_end) begin
      if (r_buf_full) begin
        r_shift     <= r_buf;
        r_data_flag <= 1'b1;
      end else begin
        r_shift     <= c_idle_frame;
        r_data_flag <= 1'b0;
      end
    end else begin
      r_shift <= {r_shift[DATA_W-2:0], 1'b0};
    end
  end

  // Holding buffer: a write at frame end keeps the buffer full while the old
  // word moves into the shift register, so nothing is lost or repeated
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else if (i_wr_en) begin
      r_buf      <= i_wr_data;
      r_buf_full <= 1'b1;
    end else if (i_frame_end) begin
      r_buf_full <= 1'b0;
    end
  end

  assign o_buf_full = r_buf_full;
  assign o_serial   = r_serial;
  assign o_valid    = r_valid;

endmodule
`default_nettype wire

// File: rtl/phy_tx_multilane.sv
`default_nettype none
// ============================================================================
// Module      : phy_tx_multilane
// Description : Multi-lane serial transmitter. Parallel words are striped
//               round-robin over LANES lockstep lanes; each lane sends one
//               DATA_W-bit frame per DATA_W clocks, MSB first, and sends the
//               idle symbol when it has no data.
// Revision    : 1.0 - initial release
// ============================================================================
module phy_tx_multilane
  import phy_tx_pkg::*;
#(
  parameter int         DATA_W   = 32,
  parameter int         LANES    = 2,
  parameter logic [7:0] IDLE_SYM = IDLE_SYM_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              validIn,
  output logic              ready_out,
  output logic [LANES-1:0]  out_tx_serial,
  output logic [LANES-1:0]  out_tx_valid
);

  localparam int                 c_cnt_w      = cnt_width(DATA_W);
  localparam int                 c_rr_w       = rr_width(LANES);
  localparam logic [c_cnt_w-1:0] c_frame_last = c_cnt_w'(DATA_W - 1);
  localparam logic [c_rr_w-1:0]  c_rr_last    = c_rr_w'(LANES - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic [c_rr_w-1:0]  r_rr;
  logic               w_frame_end;
  logic               w_target_full;
  logic               w_accept;
  logic [LANES-1:0]   w_lane_sel;
  logic [LANES-1:0]   w_buf_full;
  logic [LANES-1:0]   w_wr_en;

  // The targeted lane can take a word when its buffer is empty, or at frame
  // end when the buffered word is moving into the shift register anyway
  assign w_frame_end   = (r_cnt == c_frame_last);
  assign w_target_full = |(w_buf_full & w_lane_sel);
  assign ready_out     = !w_target_full || w_frame_end;
  assign w_accept      = validIn && ready_out;

  // Shared frame counter keeping all lanes in lockstep
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_frame_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Round-robin lane pointer, advanced only by accepted words
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr <= '0;
    end else if (w_accept) begin
      r_rr <= (r_rr == c_rr_last) ? '0 : r_rr + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane_sel[gi] = (r_rr == c_rr_w'(gi));
      assign w_wr_en[gi]    = w_accept && w_lane_sel[gi];

      phy_tx_lane #(
        .DATA_W   (DATA_W),
        .IDLE_SYM (IDLE_SYM)
      ) u_lane (
        .clk         (clk),
        .i_rst_n     (reset),
        .i_frame_end (w_frame_end),
        .i_wr_en     (w_wr_en[gi]),
        .i_wr_data   (data_in),
        .o_buf_full  (w_buf_full[gi]),
        .o_serial    (out_tx_serial[gi]),
        .o_valid     (out_tx_valid[gi])
      );
    end
  endgenerate

endmodule
`default_nettype wire
